// File: rtl/seven_seg_scan_ctrl.sv
// Scan/update controller for a multiplexed seven-segment display: blanked dead time,
// per-slot PWM brightness, and a double-buffered frame that only changes at frame boundaries.
module seven_seg_scan_ctrl #(
  parameter int N_DIGITS     = 2,
  parameter int REFRESH_DIV  = 4096,
  parameter int BLANK_CYCLES = 64,
  parameter int BRIGHT_W     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [BRIGHT_W-1:0]   brightness,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [4*N_DIGITS-1:0] wr_data,
  output logic [3:0]            digit_val,
  output logic [N_DIGITS-1:0]   digit_sel,
  output logic                  seg_blank,
  output logic                  frame_done,
  output logic [1:0]            state_dbg
);

  localparam int STEP  = (REFRESH_DIV - BLANK_CYCLES) / (2 ** BRIGHT_W);
  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(N_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BLANK = 2'd1, ON = 2'd2, OFF = 2'd3} state_t;

  state_t                  state, nxt_state;
  logic [CNT_W-1:0]        cnt, nxt_cnt;
  logic [IDX_W-1:0]        idx, nxt_idx;
  logic [BRIGHT_W-1:0]     b_lat, nxt_b;
  logic [4*N_DIGITS-1:0]   active, shadow, nxt_active;
  logic                    pending;
  logic                    accept, commit;
  logic [31:0]             on_end;

  // Handshake: a word transfers on any rising clk where wr_valid && wr_ready;
  // wr_ready is low exactly while a captured word waits for its commit.
  assign wr_ready  = !pending;
  assign accept    = wr_valid && !pending;
  assign commit    = pending && (frame_done || state == IDLE);
  assign state_dbg = state;

  assign on_end     = 32'(BLANK_CYCLES) + 32'(b_lat) * 32'(STEP);
  assign nxt_active = commit ? shadow : active;

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_idx   = idx;
    nxt_b     = b_lat;
    if (!enable) begin
      nxt_state = IDLE;
      nxt_cnt   = '0;
      nxt_idx   = '0;
    end else if (state == IDLE) begin
      nxt_state = BLANK;
      nxt_cnt   = '0;
      nxt_idx   = '0;
      nxt_b     = brightness;
    end else if (cnt == CNT_LAST) begin
      // Slot wrap: next digit, fresh brightness sample for the whole new slot.
      nxt_state = BLANK;
      nxt_cnt   = '0;
      nxt_idx   = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      nxt_b     = brightness;
    end else begin
      nxt_cnt = cnt + CNT_W'(1);
      if (32'(nxt_cnt) < 32'(BLANK_CYCLES)) begin
        nxt_state = BLANK;
      end else if (32'(nxt_cnt) < on_end) begin
        nxt_state = ON;
      end else begin
        nxt_state = OFF;
      end
    end
  end

  // Outputs are computed from next-state values so they line up with the registered state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      b_lat      <= '0;
      active     <= '0;
      shadow     <= '0;
      pending    <= 1'b0;
      digit_sel  <= '0;
      seg_blank  <= 1'b1;
      digit_val  <= '0;
      frame_done <= 1'b0;
    end else begin
      state  <= nxt_state;
      cnt    <= nxt_cnt;
      idx    <= nxt_idx;
      b_lat  <= nxt_b;
      active <= nxt_active;
      if (accept) begin
        shadow  <= wr_data;
        pending <= 1'b1;
      end else if (commit) begin
        pending <= 1'b0;
      end
      digit_sel  <= (nxt_state == ON) ? (N_DIGITS'(1) << nxt_idx) : '0;
      seg_blank  <= (nxt_state != ON);
      frame_done <= (nxt_state != IDLE) && (nxt_cnt == CNT_LAST) && (nxt_idx == IDX_LAST);
      if (nxt_state != IDLE) begin
        digit_val <= nxt_active[{nxt_idx, 2'b00} +: 4];
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with a 2-digit, 64-cycle slot, 16-cycle blank, STEP=3 setup.
module tb_seven_seg_scan_ctrl;

  localparam int N_DIGITS     = 2;
  localparam int REFRESH_DIV  = 64;
  localparam int BLANK_CYCLES = 16;
  localparam int BRIGHT_W     = 4;

  logic                  clk;
  logic                  rst_n;
  logic                  enable;
  logic [BRIGHT_W-1:0]   brightness;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [4*N_DIGITS-1:0] wr_data;
  logic [3:0]            digit_val;
  logic [N_DIGITS-1:0]   digit_sel;
  logic                  seg_blank;
  logic                  frame_done;
  logic [1:0]            state_dbg;

  int n_tests = 0;
  int n_fail  = 0;
  int slot_no = 0;
  logic [7:0] exp_q[$];    // words waiting to be offered on the write port
  logic [7:0] stage_q[$];  // words released into exp_q at a chosen slot cycle
  bit will_acc = 1'b0;

  seven_seg_scan_ctrl #(
    .N_DIGITS(N_DIGITS), .REFRESH_DIV(REFRESH_DIV),
    .BLANK_CYCLES(BLANK_CYCLES), .BRIGHT_W(BRIGHT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .brightness(brightness),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .digit_val(digit_val), .digit_sel(digit_sel), .seg_blank(seg_blank),
    .frame_done(frame_done), .state_dbg(state_dbg)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Driver: advance to the next negedge and run the write handshake one step.
  task automatic tick();
    @(negedge clk);
    if (will_acc) wr_valid = 1'b0;
    if (!wr_valid && exp_q.size() > 0) begin
      wr_data  = exp_q.pop_front();
      wr_valid = 1'b1;
    end
    will_acc = wr_valid && wr_ready;
  endtask

  task automatic check_slot(input logic [1:0] sel, input logic [3:0] val, input int on_len,
                            input bit last, input int ncyc = 64, input int wr_at = -1,
                            input int lo_first = 64, input int lo_last = -1,
                            input int b_at = -1, input logic [3:0] b_new = 4'd0);
    logic [1:0] exp_sel;
    string t;
    for (int c = 0; c < ncyc; c++) begin
      if (c == wr_at) begin
        while (stage_q.size() > 0) exp_q.push_back(stage_q.pop_front());
      end
      if (c == b_at) brightness = b_new;
      tick();
      exp_sel = (c >= BLANK_CYCLES && c < BLANK_CYCLES + on_len) ? sel : 2'b00;
      t = $sformatf("s%0d c%0d", slot_no, c);
      check({t, " sel"},   digit_sel, exp_sel);
      check({t, " blank"}, seg_blank, exp_sel == 2'b00);
      check({t, " val"},   digit_val, val);
      check({t, " fdone"}, frame_done, last && c == REFRESH_DIV - 1);
      check({t, " ready"}, wr_ready, !(c >= lo_first && c <= lo_last));
    end
    slot_no++;
  endtask

  initial begin
    rst_n = 1'b1; enable = 1'b0; brightness = '0; wr_valid = 1'b0; wr_data = '0;
    #1 rst_n = 1'b0;
    // 1. reset with random inputs
    enable     = 1'($urandom_range(0, 1));
    brightness = 4'($urandom_range(0, 15));
    wr_valid   = 1'($urandom_range(0, 1));
    wr_data    = 8'($urandom_range(0, 255));
    #2;
    check("rst sel", digit_sel, 2'b00);
    check("rst blank", seg_blank, 1'b1);
    check("rst val", digit_val, 4'h0);
    check("rst fdone", frame_done, 1'b0);
    check("rst ready", wr_ready, 1'b1);
    check("rst state", state_dbg, 2'd0);
    repeat (3) @(negedge clk);
    enable = 1'b0; wr_valid = 1'b0; wr_data = '0; brightness = '0;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("hold%0d sel", i), digit_sel, 2'b00);
      check($sformatf("hold%0d blank", i), seg_blank, 1'b1);
      check($sformatf("hold%0d val", i), digit_val, 4'h0);
      check($sformatf("hold%0d fdone", i), frame_done, 1'b0);
      check($sformatf("hold%0d ready", i), wr_ready, 1'b1);
    end

    // 2. basic scan after an idle write of 0x3A
    exp_q.push_back(8'h3A);
    tick();
    check("w0 ready", wr_ready, 1'b1);
    tick();
    check("w0 pend", wr_ready, 1'b0);
    tick();
    check("w0 commit", wr_ready, 1'b1);
    check("w0 val idle", digit_val, 4'h0);
    enable = 1'b1; brightness = 4'd15;
    check_slot(2'b01, 4'hA, 45, 0);
    check_slot(2'b10, 4'h3, 45, 1);

    // 3. tear-free update: 0x55 at cycle 30, 0x76 held behind it
    stage_q.push_back(8'h55);
    stage_q.push_back(8'h76);
    check_slot(2'b01, 4'hA, 45, 0, 64, 30, 31, 63);
    check_slot(2'b10, 4'h3, 45, 1, 64, -1, 0, 63);
    check_slot(2'b01, 4'h5, 45, 0, 64, -1, 1, 63);
    check_slot(2'b10, 4'h5, 45, 1, 64, -1, 0, 63);
    check_slot(2'b01, 4'h6, 45, 0);
    check_slot(2'b10, 4'h7, 45, 1);

    // 4. brightness 0, then 8 with a mid-ON change to 15
    brightness = 4'd0;
    check_slot(2'b01, 4'h6, 0, 0);
    check_slot(2'b10, 4'h7, 0, 1);
    brightness = 4'd8;
    check_slot(2'b01, 4'h6, 24, 0, 64, -1, 64, -1, 25, 4'd15);
    check_slot(2'b10, 4'h7, 45, 1);

    // 5. enable drop during digit 1 ON, write while disabled, re-enable
    check_slot(2'b01, 4'h6, 45, 0);
    check_slot(2'b10, 4'h7, 45, 0, 20);
    enable = 1'b0;
    exp_q.push_back(8'h21);
    tick();
    check("dis sel", digit_sel, 2'b00);
    check("dis blank", seg_blank, 1'b1);
    check("dis fdone", frame_done, 1'b0);
    check("dis val hold", digit_val, 4'h7);
    tick();
    check("dis pend", wr_ready, 1'b0);
    tick();
    check("dis commit", wr_ready, 1'b1);
    check("dis val hold2", digit_val, 4'h7);
    enable = 1'b1;
    check_slot(2'b01, 4'h1, 45, 0);
    check_slot(2'b10, 4'h2, 45, 1);

    // 6. async reset during ON with a write pending
    stage_q.push_back(8'h99);
    check_slot(2'b01, 4'h1, 45, 0, 30, 20, 21, 29);
    #2 rst_n = 1'b0;
    #1;
    check("arst sel", digit_sel, 2'b00);
    check("arst blank", seg_blank, 1'b1);
    check("arst val", digit_val, 4'h0);
    check("arst ready", wr_ready, 1'b1);
    check("arst fdone", frame_done, 1'b0);
    check("arst state", state_dbg, 2'd0);
    enable = 1'b0; wr_valid = 1'b0; will_acc = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post val", digit_val, 4'h0);
    check("post ready", wr_ready, 1'b1);
    enable = 1'b1;
    check_slot(2'b01, 4'h0, 45, 0);
    check_slot(2'b10, 4'h0, 45, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
